// File: rtl/if_pc_predict.sv
// Instruction-fetch PC register with next-PC selection and a direct-mapped BTB
// holding 2-bit saturating direction counters.
module if_pc_predict #(
  parameter int                ADDR_W      = 32,
  parameter int                BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              epc_ctrl,
  input  logic [ADDR_W-1:0] jumpAddressExcept,
  input  logic              id_isBranch,
  input  logic              id_shouldJumpOrBranch,
  input  logic [ADDR_W-1:0] id_jumpOrBranchPc,
  input  logic [ADDR_W-1:0] id_branchPc,
  input  logic              id_predTaken,
  input  logic [ADDR_W-1:0] id_predTarget,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_4,
  output logic              predTaken,
  output logic [ADDR_W-1:0] predTarget,
  output logic              if_valid,
  output logic              flush
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int TGT_W = ADDR_W - 2;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;

  logic [BTB_ENTRIES-1:0]            btb_valid;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] btb_tag;
  logic [BTB_ENTRIES-1:0][TGT_W-1:0] btb_tgt;
  logic [BTB_ENTRIES-1:0][1:0]       btb_ctr;

  // Fetch-side lookup, purely combinational on the current PC
  logic [IDX_W-1:0] lk_idx;
  logic             lk_hit;

  assign lk_idx     = pc_q[IDX_W+1:2];
  assign lk_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == pc_q[ADDR_W-1:IDX_W+2]);
  assign predTaken  = lk_hit && btb_ctr[lk_idx][1];
  assign predTarget = predTaken ? {btb_tgt[lk_idx], 2'b00} : '0;
  assign pc_4       = pc_q + ADDR_W'(4);
  assign pc         = pc_q;
  assign if_valid   = if_valid_q;

  logic              upd_en;
  logic              mispredict;
  logic [ADDR_W-1:0] correct_pc;

  assign upd_en     = id_isBranch && !stall;
  assign mispredict = upd_en &&
                      ((id_shouldJumpOrBranch != id_predTaken) ||
                       (id_shouldJumpOrBranch && id_predTaken &&
                        (id_jumpOrBranchPc != id_predTarget)));
  assign correct_pc = id_shouldJumpOrBranch ? id_jumpOrBranchPc : id_branchPc + ADDR_W'(4);
  assign flush      = epc_ctrl || mispredict;

  always_comb begin
    pc_d = pc_4;
    if (epc_ctrl)        pc_d = jumpAddressExcept;
    else if (mispredict) pc_d = correct_pc;
    else if (stall)      pc_d = pc_q;
    else if (predTaken)  pc_d = predTarget;
    pc_d[1:0]  = 2'b00;
    if_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Resolution-side update, indexed and tagged by the resolving instruction's PC
  logic [IDX_W-1:0] wr_idx_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [TGT_W-1:0] wr_tgt_d;
  logic [1:0]       wr_ctr_d;
  logic             wr_en_d;
  logic             upd_hit;
  logic [1:0]       upd_ctr;

  assign wr_idx_d = id_branchPc[IDX_W+1:2];
  assign wr_tag_d = id_branchPc[ADDR_W-1:IDX_W+2];
  assign upd_hit  = btb_valid[wr_idx_d] && (btb_tag[wr_idx_d] == wr_tag_d);
  assign upd_ctr  = btb_ctr[wr_idx_d];

  always_comb begin
    wr_en_d  = upd_en && (upd_hit || id_shouldJumpOrBranch);
    wr_tgt_d = id_shouldJumpOrBranch ? id_jumpOrBranchPc[ADDR_W-1:2] : btb_tgt[wr_idx_d];
    wr_ctr_d = 2'd2;
    if (upd_hit) begin
      if (id_shouldJumpOrBranch) wr_ctr_d = (upd_ctr == 2'd3) ? 2'd3 : upd_ctr + 2'd1;
      else                       wr_ctr_d = (upd_ctr == 2'd0) ? 2'd0 : upd_ctr - 2'd1;
    end
  end

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [TGT_W-1:0] tgt_q;
    logic [1:0]       ctr_q;
    logic             sel;

    assign sel = wr_en_d && (wr_idx_d == IDX_W'(gi));

    // Only the valid bit is reset; the payload is meaningless until allocated
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (sel) begin
        valid_q <= 1'b1;
        tag_q   <= wr_tag_d;
        tgt_q   <= wr_tgt_d;
        ctr_q   <= wr_ctr_d;
      end
    end

    assign btb_valid[gi] = valid_q;
    assign btb_tag[gi]   = tag_q;
    assign btb_tgt[gi]   = tgt_q;
    assign btb_ctr[gi]   = ctr_q;
  end
endmodule

// File: tb/tb_if_pc_predict.sv
// Directed bench for if_pc_predict: each driven cycle queues its hand-computed
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_if_pc_predict;
  logic        clk = 1'b0;
  logic        rst, stall, epc_ctrl, id_isBranch, id_shouldJumpOrBranch, id_predTaken;
  logic [31:0] jumpAddressExcept, id_jumpOrBranchPc, id_branchPc, id_predTarget;
  logic [31:0] pc, pc_4, predTarget;
  logic        predTaken, if_valid, flush;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        fl;
    logic        iv;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  if_pc_predict #(.ADDR_W(32), .BTB_ENTRIES(16), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .epc_ctrl(epc_ctrl),
    .jumpAddressExcept(jumpAddressExcept), .id_isBranch(id_isBranch),
    .id_shouldJumpOrBranch(id_shouldJumpOrBranch), .id_jumpOrBranchPc(id_jumpOrBranchPc),
    .id_branchPc(id_branchPc), .id_predTaken(id_predTaken), .id_predTarget(id_predTarget),
    .pc(pc), .pc_4(pc_4), .predTaken(predTaken), .predTarget(predTarget),
    .if_valid(if_valid), .flush(flush)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per clock cycle, checked mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "pc", pc, e.pc);
      chk(e.nm, "pc_4", pc_4, e.pc + 32'd4);
      chk(e.nm, "predTaken", {31'b0, predTaken}, {31'b0, e.pt});
      chk(e.nm, "predTarget", predTarget, e.ptgt);
      chk(e.nm, "flush", {31'b0, flush}, {31'b0, e.fl});
      chk(e.nm, "if_valid", {31'b0, if_valid}, {31'b0, e.iv});
      $display("%-12s pc=%h pc_4=%h predTaken=%0b predTarget=%h flush=%0b if_valid=%0b",
               e.nm, pc, pc_4, predTaken, predTarget, flush, if_valid);
    end
  end

  task automatic idle();
    stall = 0; epc_ctrl = 0; jumpAddressExcept = '0;
    id_isBranch = 0; id_shouldJumpOrBranch = 0; id_jumpOrBranchPc = '0;
    id_branchPc = '0; id_predTaken = 0; id_predTarget = '0;
  endtask

  task automatic except(input logic [31:0] a);
    epc_ctrl = 1; jumpAddressExcept = a;
  endtask

  task automatic resolve(input logic [31:0] bpc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptg);
    id_isBranch = 1; id_branchPc = bpc; id_shouldJumpOrBranch = tk;
    id_jumpOrBranchPc = tgt; id_predTaken = ptk; id_predTarget = ptg;
  endtask

  task automatic step(input string nm, input logic [31:0] p, input logic pt,
                      input logic [31:0] tg, input logic fl, input logic iv);
    exp_t e;
    e.nm = nm; e.pc = p; e.pt = pt; e.ptgt = tg; e.fl = fl; e.iv = iv;
    sb.push_back(e);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); rst = 1;
    @(posedge clk); #1;
    step("rst0",  32'h100, 0, 0, 0, 0);
    step("rst1",  32'h100, 0, 0, 0, 0);
    rst = 0;
    step("release", 32'h100, 0, 0, 0, 0);
    step("seq1",  32'h104, 0, 0, 0, 1);
    step("seq2",  32'h108, 0, 0, 0, 1);
    resolve(32'h200, 1, 32'h400, 0, 0);
    step("alloc", 32'h10C, 0, 0, 1, 1);
    step("redir", 32'h400, 0, 0, 0, 1);
    except(32'h203);
    step("epc_a", 32'h404, 0, 0, 1, 1);
    step("pred",  32'h200, 1, 32'h400, 0, 1);
    step("pred_nb", 32'h400, 0, 0, 0, 1);
    resolve(32'h200, 0, 0, 0, 0);
    step("nt1",   32'h404, 0, 0, 0, 1);
    resolve(32'h200, 0, 0, 0, 0);
    step("nt2",   32'h408, 0, 0, 0, 1);
    except(32'h200);
    step("epc_b", 32'h40C, 0, 0, 1, 1);
    step("weak",  32'h200, 0, 0, 0, 1);
    resolve(32'h200, 1, 32'h480, 1, 32'h400);
    step("wrong_tgt", 32'h204, 0, 0, 1, 1);
    resolve(32'h200, 1, 32'h480, 1, 32'h480);
    step("ok_tgt", 32'h480, 0, 0, 0, 1);
    except(32'h200);
    step("epc_c", 32'h484, 0, 0, 1, 1);
    step("new_tgt", 32'h200, 1, 32'h480, 0, 1);
    resolve(32'h200, 0, 0, 1, 32'h480);
    step("wrong_dir", 32'h480, 0, 0, 1, 1);
    step("fallthru", 32'h204, 0, 0, 0, 1);
    except(32'h80); resolve(32'h200, 1, 32'h300, 0, 0); stall = 1;
    step("prio",  32'h208, 0, 0, 1, 1);
    stall = 1;
    step("stall1", 32'h80, 0, 0, 0, 1);
    stall = 1;
    step("stall2", 32'h80, 0, 0, 0, 1);
    stall = 1;
    step("stall3", 32'h80, 0, 0, 0, 1);
    step("unstall", 32'h80, 0, 0, 0, 1);
    except(32'h200);
    step("epc_d", 32'h84, 0, 0, 1, 1);
    step("no_upd", 32'h200, 0, 0, 0, 1);
    resolve(32'h200, 1, 32'h500, 0, 0);
    step("alias_a", 32'h204, 0, 0, 1, 1);
    resolve(32'h240, 1, 32'h600, 0, 0);
    step("alias_b", 32'h500, 0, 0, 1, 1);
    except(32'h200);
    step("epc_e", 32'h600, 0, 0, 1, 1);
    step("alias_miss", 32'h200, 0, 0, 0, 1);
    except(32'h240);
    step("epc_f", 32'h204, 0, 0, 1, 1);
    step("alias_hit", 32'h240, 1, 32'h600, 0, 1);
    except(32'hFFFF_FFFC);
    step("epc_g", 32'h600, 0, 0, 1, 1);
    step("wrap",  32'hFFFF_FFFC, 0, 0, 0, 1);
    step("wrapped", 32'h0, 0, 0, 0, 1);
    resolve(32'hFFFF_FFFC, 0, 0, 1, 32'h100);
    step("bpc_wrap", 32'h4, 0, 0, 1, 1);
    step("bpc_wrapped", 32'h0, 0, 0, 0, 1);
    rst = 1; except(32'h80); resolve(32'h200, 1, 32'h700, 0, 0);
    step("rst_mid", 32'h4, 0, 0, 1, 1);
    rst = 0;
    step("rst_out", 32'h100, 0, 0, 0, 0);
    except(32'h240);
    step("epc_h", 32'h104, 0, 0, 1, 1);
    step("cleared", 32'h240, 0, 0, 0, 1);

    repeat (4) begin
      if (sb.size() != 0) @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
